lcd_fill_engine: RTL and testbench
==================================

# lcd_fill_engine

Rectangle fill and test-pattern generator that sits directly upstream of `ili934x_driver` and drives its host-control port. It accepts one fill command at a time: a rectangle, a colour and a pattern mode. For each command it waits for the panel to finish init, programs the window, starts a pixel stream, and emits exactly (x1−x0+1)·(y1−y0+1) pixels under the driver's valid/ready handshake. It reports completion only after the driver has gone idle.

## Interface
- `X_RES`, 240, panel width in pixels; commands with x1 ≥ X_RES are rejected.
- `Y_RES`, 320, panel height in pixels; commands with y1 ≥ Y_RES are rejected.
- `BAR_W`, 30, colour-bar width in pixels, ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block idle, command accepted on `cmd_valid & cmd_ready`.
- `cmd_x0`, `cmd_y0`, `cmd_x1`, `cmd_y1`  in  16 each  inclusive rectangle corners.
- `cmd_color`  in  16  RGB565 colour.
- `cmd_mode`  in  2  fill mode: 0 = solid, 1 = colour bars, 2 = checker, 3 = solid.
- `abort`  in  1  synchronous cancel of the current command.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse when a command is rejected.
- `active`  out  1  high in every state except IDLE.
- `init_done`  in  1  from the driver.
- `drv_busy`  in  1  the driver's `busy` output.
- `win_set_stb`  out  1  one-cycle window strobe.
- `win_x0`, `win_y0`, `win_x1`, `win_y1`  out  16 each  latched rectangle.
- `stream_start`  out  1  one-cycle stream start.
- `pix_data`  out  16  pixel value.
- `pix_valid`  out  1  pixel offered.
- `pix_ready`  in  1  driver accepts the pixel.

## Operation
- **States:** IDLE, WAIT_RDY, SET_WIN, START, STREAM, DRAIN, DONE.
- **IDLE:** `cmd_ready` = 1. On acceptance, latch all command fields.
  - Valid command: x0 ≤ x1 < X_RES and y0 ≤ y1 < Y_RES. Go to WAIT_RDY.
  - Invalid command: pulse `err` for 1 cycle and stay in IDLE.
- **WAIT_RDY:** leave when `init_done` = 1 and `drv_busy` = 0, then go to SET_WIN.
- **SET_WIN:** `win_set_stb` = 1 for 1 cycle, then go to START.
- **START:** `stream_start` = 1 for 1 cycle. Load x = x0, y = y0, then go to STREAM.
- **STREAM:** `pix_valid` = 1. Each accepted pixel advances the counters.
  - x increments until it reaches x1; the next step wraps x to x0 and increments y.
  - When the pixel at (x1, y1) is accepted, go to DRAIN.
- **DRAIN:** wait for `drv_busy` = 0, then go to DONE.
- **DONE:** `done` = 1 for 1 cycle, then go to IDLE.
- **Patterns** use relative coordinates rx = x−x0, ry = y−y0.
  - Solid: every pixel is `cmd_color`.
  - Bars: a bar-column counter counts 0..BAR_W−1 and resets at every row start. On each wrap it advances a 3-bit bar index mod 8. The index selects, in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. No divider is used.
  - Checker: pixel is `cmd_color` when (rx[3] ^ ry[3]) = 0, else 0000.
- **Counters:** x and y are 16 bits; no pixel-total counter is needed.
- **`abort`:** in any non-IDLE state, the next state is IDLE. `pix_valid` and all strobes drop, and no `done` is produced. `abort` in IDLE is ignored.
- **`init_done` falling mid-command:** ignored; there is no auto-abort.
- **`cmd_valid` while not IDLE:** not accepted; `cmd_ready` = 0.

## Timing
- **Reset:** state is IDLE. All outputs are 0 except `cmd_ready` = 1. The `win_*` outputs and `pix_data` reset to 0.
- **Registered outputs:** all outputs except `cmd_ready` are registered. `cmd_ready` is decoded from state = IDLE.
- **Start-up latency**, with the driver already ready:
  - cycle 0: command accepted.
  - cycle 1: WAIT_RDY.
  - cycle 2: `win_set_stb`.
  - cycle 3: `stream_start`.
  - cycle 4: first `pix_valid`.
- **`win_*` outputs:** stable from SET_WIN until the next accepted command.
- **Stalls:** while `pix_valid & !pix_ready`, `pix_data` and `pix_valid` hold. With `pix_ready` held at 1, one pixel transfers per cycle with no bubbles, including across row wraps.
- **1×1 rectangle:** exactly one pixel is sent, then DRAIN.
- **`done`:** asserted on the cycle after the first cycle in DRAIN that sees `drv_busy` = 0.

## Structure
- **`ili934x_pkg` additions:**
  - `fill_mode_t` enum: SOLID, BARS, CHECK.
  - `fill_cmd_t` struct: x0, y0, x1, y1, color, mode.
  - The eight bar-colour localparams.
- **Sub-module `fill_pattern_gen`:** holds the x/y, bar and checker counters. Inputs are load/advance; outputs are the pixel value and a last flag. The FSM stays in `lcd_fill_engine`.

## Test plan
- **Solid fill:** rect (0,0)-(3,1), colour F800, `pix_ready` = 1 → strobes at cycles 2 and 3, then 8 pixels of F800 on cycles 4–11, then `done` once `drv_busy` drops.
- **Colour bars:** rect (0,0)-(239,0), mode 1, BAR_W 30 → each block of 30 pixels equals the bar table in order.
- **Checker with backpressure:** rect (0,0)-(15,15), mode 2, colour 07E0, random `pix_ready` → 256 pixels; (8,0) = 0000, (8,8) = 07E0; data held stable during stalls.
- **Rejected commands:** rect (5,0)-(4,0), and separately x1 = 240 → `err` pulses, no `win_set_stb`, `cmd_ready` stays 1.
- **Gating:** `init_done` = 0 for 100 cycles → no `win_set_stb` until it rises. `drv_busy` held 1 after the last pixel → `done` is delayed.
- **Abort and reset mid-stream:** `abort` after 3 pixels → IDLE, `pix_valid` = 0, no `done`, next command runs normally. `rst_n` low mid-STREAM → all outputs at reset values immediately.

Source files
------------

// File: rtl/ili934x_pkg.sv
// Shared types and constants for the ILI934x panel path: fill command
// format, fill-engine FSM states and the colour-bar palette.
package ili934x_pkg;

  typedef enum logic [1:0] {
    SOLID = 2'd0,
    BARS  = 2'd1,
    CHECK = 2'd2
  } fill_mode_t;

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] color;
    fill_mode_t  mode;
  } fill_cmd_t;

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, SET_WIN, START, STREAM, DRAIN, DONE
  } fill_state_t;

  // RGB565 colour-bar palette, left to right
  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_fill_engine_pattern.sv
// Pixel walker for the fill engine: x/y raster counters plus the bar
// counters, producing a registered pixel value for the current position
// and a flag marking the final pixel of the rectangle.
module fill_pattern_gen
  import ili934x_pkg::*;
#(
  parameter int BAR_W = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  fill_cmd_t   cfg,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] pix_data,
  output logic        last
);

  localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

  logic [15:0] x, y, bar_cnt;
  logic [2:0]  bar_idx;
  logic [15:0] nx, ny, nbar_cnt;
  logic [2:0]  nbar_idx;
  logic [15:0] npix;
  logic        rx3, ry3;

  // Next raster position: load jumps to the top-left corner, otherwise step
  // right, wrapping to the next row (and restarting the bars) at x1.
  always_comb begin
    nx       = x;
    ny       = y;
    nbar_cnt = bar_cnt;
    nbar_idx = bar_idx;
    if (load) begin
      nx       = cfg.x0;
      ny       = cfg.y0;
      nbar_cnt = '0;
      nbar_idx = '0;
    end else if (x == cfg.x1) begin
      nx       = cfg.x0;
      ny       = y + 16'd1;
      nbar_cnt = '0;
      nbar_idx = '0;
    end else begin
      nx = x + 16'd1;
      if (bar_cnt == BAR_LAST) begin
        nbar_cnt = '0;
        nbar_idx = bar_idx + 3'd1;
      end else begin
        nbar_cnt = bar_cnt + 16'd1;
      end
    end
  end

  // Pixel value at the next position. Bit 3 of (n - origin) is formed from
  // bit 3 of each operand plus the borrow out of the low three bits.
  always_comb begin
    rx3 = nx[3] ^ cfg.x0[3] ^ (nx[2:0] < cfg.x0[2:0]);
    ry3 = ny[3] ^ cfg.y0[3] ^ (ny[2:0] < cfg.y0[2:0]);
    case (cfg.mode)
      BARS:    npix = bar_color(nbar_idx);
      CHECK:   npix = (rx3 ^ ry3) ? BAR_BLACK : cfg.color;
      default: npix = cfg.color;
    endcase
  end

  // Counter and pixel registers move together on load or accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      bar_cnt  <= '0;
      bar_idx  <= '0;
      pix_data <= '0;
      last     <= 1'b0;
    end else if (load || advance) begin
      x        <= nx;
      y        <= ny;
      bar_cnt  <= nbar_cnt;
      bar_idx  <= nbar_idx;
      pix_data <= npix;
      last     <= (nx == cfg.x1) && (ny == cfg.y1);
    end
  end

endmodule

// File: rtl/lcd_fill_engine.sv
// Rectangle fill / test-pattern engine driving the ILI934x driver's host
// port: validates a command, waits for the panel, programs the window and
// streams the rectangle's pixels under valid/ready.
module lcd_fill_engine
  import ili934x_pkg::*;
#(
  parameter int X_RES = 240,
  parameter int Y_RES = 320,
  parameter int BAR_W = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_x0,
  input  logic [15:0] cmd_y0,
  input  logic [15:0] cmd_x1,
  input  logic [15:0] cmd_y1,
  input  logic [15:0] cmd_color,
  input  logic [1:0]  cmd_mode,
  input  logic        abort,
  output logic        done,
  output logic        err,
  output logic        active,
  input  logic        init_done,
  input  logic        drv_busy,
  output logic        win_set_stb,
  output logic [15:0] win_x0,
  output logic [15:0] win_y0,
  output logic [15:0] win_x1,
  output logic [15:0] win_y1,
  output logic        stream_start,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready
);

  fill_state_t state;
  fill_cmd_t   cmd;
  logic        cmd_ok;
  logic        last;
  logic        gen_load, gen_advance;

  assign cmd_ready = (state == IDLE);
  assign cmd_ok    = (cmd_x0 <= cmd_x1) && (cmd_x1 < 16'(X_RES)) &&
                     (cmd_y0 <= cmd_y1) && (cmd_y1 < 16'(Y_RES));

  // Abort wins over any counter movement in the same cycle
  assign gen_load    = (state == START)  && !abort;
  assign gen_advance = (state == STREAM) && pix_ready && !abort;

  fill_pattern_gen #(.BAR_W(BAR_W)) u_pattern (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (cmd),
    .load     (gen_load),
    .advance  (gen_advance),
    .pix_data (pix_data),
    .last     (last)
  );

  // Command FSM; every output is set on the transition into its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd          <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      active       <= 1'b0;
      win_set_stb  <= 1'b0;
      stream_start <= 1'b0;
      pix_valid    <= 1'b0;
      win_x0       <= '0;
      win_y0       <= '0;
      win_x1       <= '0;
      win_y1       <= '0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      win_set_stb  <= 1'b0;
      stream_start <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        active    <= 1'b0;
        pix_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              cmd.x0    <= cmd_x0;
              cmd.y0    <= cmd_y0;
              cmd.x1    <= cmd_x1;
              cmd.y1    <= cmd_y1;
              cmd.color <= cmd_color;
              // mode 3 is an alias for solid
              cmd.mode  <= (cmd_mode == 2'd3) ? SOLID : fill_mode_t'(cmd_mode);
              if (cmd_ok) begin
                state  <= WAIT_RDY;
                active <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          WAIT_RDY: begin
            if (init_done && !drv_busy) begin
              state       <= SET_WIN;
              win_set_stb <= 1'b1;
              win_x0      <= cmd.x0;
              win_y0      <= cmd.y0;
              win_x1      <= cmd.x1;
              win_y1      <= cmd.y1;
            end
          end
          SET_WIN: begin
            state        <= START;
            stream_start <= 1'b1;
          end
          START: begin
            state     <= STREAM;
            pix_valid <= 1'b1;
          end
          STREAM: begin
            if (pix_ready && last) begin
              state     <= DRAIN;
              pix_valid <= 1'b0;
            end
          end
          DRAIN: begin
            if (!drv_busy) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state  <= IDLE;
            active <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            active    <= 1'b0;
            pix_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_fill_engine.sv
// Directed bench for lcd_fill_engine: latency, solid/bars/checker content,
// backpressure, rejection, gating, abort and asynchronous reset.
module tb_lcd_fill_engine;

  localparam int BAR_W = 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color;
  logic [1:0]  cmd_mode;
  logic        abort, done, err, active, init_done, drv_busy;
  logic        win_set_stb, stream_start, pix_valid, pix_ready;
  logic [15:0] win_x0, win_y0, win_x1, win_y1, pix_data;

  int tests = 0;
  int fails = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  always #5 clk = ~clk;

  lcd_fill_engine #(.X_RES(240), .Y_RES(320), .BAR_W(BAR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_mode(cmd_mode),
    .abort(abort), .done(done), .err(err), .active(active),
    .init_done(init_done), .drv_busy(drv_busy),
    .win_set_stb(win_set_stb),
    .win_x0(win_x0), .win_y0(win_y0), .win_x1(win_x1), .win_y1(win_y1),
    .stream_start(stream_start), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int mode, input logic [15:0] color,
                                          input int rx, input int ry);
    if (mode == 1) return bars[(rx / BAR_W) % 8];
    if (mode == 2) return ((((rx >> 3) ^ (ry >> 3)) & 1) != 0) ? 16'h0000 : color;
    return color;
  endfunction

  task automatic set_cmd(input int x0, input int y0, input int x1, input int y1,
                         input logic [15:0] color, input int mode);
    cmd_x0    = 16'(x0);
    cmd_y0    = 16'(y0);
    cmd_x1    = 16'(x1);
    cmd_y1    = 16'(y1);
    cmd_color = color;
    cmd_mode  = 2'(mode);
  endtask

  // Full command with driver ready: checks start-up latency, every pixel,
  // stall stability, the pixel count and the done timing after drv_busy.
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input logic [15:0] color, input int mode, input bit rnd,
                         input int busy_hold, input string tag);
    int npix, w, cx, cy, got;
    bit stalled, pr;
    logic [15:0] held;
    set_cmd(x0, y0, x1, y1, color, mode);
    cmd_valid = 1'b1;
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(negedge clk);                       // cycle 1
    cmd_valid = 1'b0;
    chk({tag, ".c1"}, {active, cmd_ready, win_set_stb}, 3'b100);
    @(negedge clk);                       // cycle 2
    chk({tag, ".win_stb"}, {win_set_stb, stream_start}, 2'b10);
    chk({tag, ".win"}, {win_x0, win_y0, win_x1, win_y1},
        {16'(x0), 16'(y0), 16'(x1), 16'(y1)});
    @(negedge clk);                       // cycle 3
    chk({tag, ".start"}, {win_set_stb, stream_start, pix_valid}, 3'b010);
    if (busy_hold > 0) drv_busy = 1'b1;
    @(negedge clk);                       // cycle 4
    chk({tag, ".first"}, 64'(pix_valid), 64'd1);
    w = x1 - x0 + 1;
    npix = w * (y1 - y0 + 1);
    cx = 0; cy = 0; got = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 4000 && got < npix; c++) begin
      if (stalled) chk({tag, ".hold"}, {pix_valid, pix_data}, {1'b1, held});
      if (!rnd && pix_valid !== 1'b1) chk({tag, ".bubble"}, 64'(pix_valid), 64'd1);
      pr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_ready = pr;
      stalled = 1'b0;
      if (pix_valid) begin
        if (pr) begin
          chk($sformatf("%s.pix(%0d,%0d)", tag, cx, cy), 64'(pix_data),
              64'(exp_pix(mode, color, cx, cy)));
          got++;
          cx++;
          if (cx == w) begin cx = 0; cy++; end
        end else begin
          stalled = 1'b1;
          held = pix_data;
        end
      end
      @(negedge clk);
    end
    pix_ready = 1'b0;
    chk({tag, ".count"}, 64'(got), 64'(npix));
    chk({tag, ".drain"}, {pix_valid, done, active}, 3'b001);
    for (int h = 0; h < busy_hold; h++) begin
      @(negedge clk);
      chk({tag, ".busy_hold"}, {done, active}, 2'b01);
    end
    drv_busy = 1'b0;
    @(negedge clk);
    chk({tag, ".done"}, 64'(done), 64'd1);
    @(negedge clk);
    chk({tag, ".idle"}, {done, active, cmd_ready}, 3'b001);
  endtask

  task automatic reject(input int x0, input int y0, input int x1, input int y1,
                        input string tag);
    bit seen;
    set_cmd(x0, y0, x1, y1, 16'hABCD, 0);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, ".err"}, {err, cmd_ready, active}, 3'b110);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | win_set_stb | err | ~cmd_ready;
    end
    chk({tag, ".quiet"}, 64'(seen), 64'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    init_done = 1'b1; drv_busy = 1'b0;
    set_cmd(0, 0, 0, 0, 16'h0, 0);
    @(negedge clk); @(negedge clk);
    chk("reset.ctrl", {cmd_ready, active, done, err, win_set_stb, stream_start, pix_valid},
        7'b1000000);
    chk("reset.data", {win_x0, win_y0, win_x1, win_y1}, 64'd0);
    chk("reset.pix", 64'(pix_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(0, 0, 3, 1, 16'hF800, 0, 1'b0, 3, "solid");
    run_cmd(0, 0, 239, 0, 16'h1111, 1, 1'b0, 0, "bars");
    run_cmd(200, 5, 239, 6, 16'h1111, 1, 1'b0, 0, "bars2row");
    run_cmd(0, 0, 15, 15, 16'h07E0, 2, 1'b1, 0, "checker");
    run_cmd(10, 20, 12, 21, 16'h5A5A, 3, 1'b1, 2, "mode3");

    reject(5, 0, 4, 0, "rej_x");
    reject(0, 0, 240, 0, "rej_xres");
    reject(0, 0, 0, 320, "rej_yres");

    // init_done low holds the command in WAIT_RDY
    init_done = 1'b0;
    set_cmd(2, 3, 5, 4, 16'h0F0F, 0);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      seen = seen | win_set_stb;
      @(negedge clk);
    end
    chk("gate.nostb", {seen, active}, 2'b01);
    init_done = 1'b1;
    @(negedge clk);
    chk("gate.stb", 64'(win_set_stb), 64'd1);
    chk("gate.win", {win_x0, win_y0, win_x1, win_y1}, {16'd2, 16'd3, 16'd5, 16'd4});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("gate.abort", {active, cmd_ready, stream_start, pix_valid}, 4'b0100);
    chk("gate.win_hold", {win_x0, win_y0, win_x1, win_y1}, {16'd2, 16'd3, 16'd5, 16'd4});

    // abort after three pixels
    set_cmd(0, 0, 9, 0, 16'h001F, 0);
    pix_ready = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.streaming", 64'(pix_valid), 64'd1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pix_ready = 1'b0;
    chk("abort.idle", {pix_valid, active, cmd_ready}, 3'b001);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | done | pix_valid;
    end
    chk("abort.nodone", 64'(seen), 64'd0);
    run_cmd(7, 9, 7, 9, 16'h1234, 0, 1'b0, 0, "one_px");

    // asynchronous reset mid-stream
    set_cmd(0, 0, 19, 0, 16'h0, 1);
    pix_ready = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst.streaming", 64'(pix_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.ctrl", {cmd_ready, active, done, err, win_set_stb, stream_start, pix_valid},
        7'b1000000);
    chk("rst.data", {win_x0, win_y0, win_x1, win_y1}, 64'd0);
    chk("rst.pix", 64'(pix_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_ready = 1'b0;
    @(negedge clk);
    run_cmd(1, 1, 2, 2, 16'hCAFE, 0, 1'b0, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
